// File: rtl/color_sequencer.sv
// rtl/color_sequencer.sv - breath-stepped colour index with a debounced mode button
module color_sequencer #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd156250,
  parameter logic [2:0]  INIT_COLOR      = 3'b001
) (
  input  logic       clk_div_i,
  input  logic       rst_i,
  input  logic       breath_clk_i,
  input  logic       btn_i,
  output logic [2:0] rgb_o,
  output logic [1:0] mode_o,
  output logic       step_o
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_FWD  = 2'd1,
    MODE_REV  = 2'd2,
    MODE_OFF  = 2'd3
  } mode_e;

  logic        br_meta_q, br_meta_d;
  logic        br_sync_q, br_sync_d;
  logic        br_dly_q,  br_dly_d;
  logic [1:0]  br_vld_q,  br_vld_d;
  logic        br_arm_q,  br_arm_d;
  logic        bt_meta_q, bt_meta_d;
  logic        bt_sync_q, bt_sync_d;
  logic        db_level_q, db_level_d;
  logic [31:0] db_cnt_q,  db_cnt_d;
  logic        press_q,   press_d;
  mode_e       mode_q,    mode_d;
  logic [2:0]  idx_q,     idx_d;
  logic [2:0]  rgb_q,     rgb_d;
  logic        step_q,    step_d;
  logic        breath_evt;

  always_comb begin
    br_meta_d  = breath_clk_i;
    br_sync_d  = br_meta_q;
    br_dly_d   = br_sync_q;
    br_vld_d   = {br_vld_q[0], 1'b1};
    // A rise is only trusted once a genuine low sample has passed the synchronizer,
    // so a level already high across reset release never counts as an edge.
    br_arm_d   = br_arm_q | (br_vld_q[1] & ~br_sync_q);
    breath_evt = br_arm_q & br_sync_q & ~br_dly_q;

    bt_meta_d  = btn_i;
    bt_sync_d  = bt_meta_q;
    db_level_d = db_level_q;
    db_cnt_d   = 32'd0;
    if (bt_sync_q != db_level_q) begin
      if (db_cnt_q >= DEBOUNCE_CYCLES - 32'd1) begin
        db_level_d = bt_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 32'd1;
      end
    end
    press_d = db_level_d & ~db_level_q;

    mode_d = mode_q;
    if (press_q) begin
      case (mode_q)
        MODE_HOLD: mode_d = MODE_FWD;
        MODE_FWD:  mode_d = MODE_REV;
        MODE_REV:  mode_d = MODE_OFF;
        default:   mode_d = MODE_HOLD;
      endcase
    end

    // The step direction uses the mode before any change landing on the same edge.
    idx_d = idx_q;
    if (breath_evt) begin
      case (mode_q)
        MODE_FWD: idx_d = (idx_q == 3'd7) ? 3'd1 : idx_q + 3'd1;
        MODE_REV: idx_d = (idx_q == 3'd1) ? 3'd7 : idx_q - 3'd1;
        default:  idx_d = idx_q;
      endcase
    end

    step_d = (idx_d != idx_q);
    rgb_d  = (mode_q == MODE_OFF) ? 3'd0 : idx_q;
  end

  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      br_meta_q  <= 1'b0;
      br_sync_q  <= 1'b0;
      br_dly_q   <= 1'b0;
      br_vld_q   <= 2'b00;
      br_arm_q   <= 1'b0;
      bt_meta_q  <= 1'b0;
      bt_sync_q  <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= 32'd0;
      press_q    <= 1'b0;
      mode_q     <= MODE_FWD;
      idx_q      <= INIT_COLOR;
      rgb_q      <= INIT_COLOR;
      step_q     <= 1'b0;
    end else begin
      br_meta_q  <= br_meta_d;
      br_sync_q  <= br_sync_d;
      br_dly_q   <= br_dly_d;
      br_vld_q   <= br_vld_d;
      br_arm_q   <= br_arm_d;
      bt_meta_q  <= bt_meta_d;
      bt_sync_q  <= bt_sync_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      rgb_q      <= rgb_d;
      step_q     <= step_d;
    end
  end

  assign rgb_o  = rgb_q;
  assign mode_o = mode_q;
  assign step_o = step_q;

endmodule
